// File: rtl/mem_split_arb2.sv
// Two-master arbiter onto one MemSplit32 slave: round-robin command grant with
// hold-until-ack, plus an in-order ID FIFO that routes read responses back.
module mem_split_arb2 #(
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  m0_req_i,
  input  logic                                  m0_we_i,
  input  logic [31:0]                           m0_addr_i,
  input  logic [31:0]                           m0_wdata_i,
  input  logic [3:0]                            m0_be_i,
  output logic                                  m0_ack_o,
  output logic                                  m0_resp_o,
  output logic [31:0]                           m0_rdata_o,
  input  logic                                  m1_req_i,
  input  logic                                  m1_we_i,
  input  logic [31:0]                           m1_addr_i,
  input  logic [31:0]                           m1_wdata_i,
  input  logic [3:0]                            m1_be_i,
  output logic                                  m1_ack_o,
  output logic                                  m1_resp_o,
  output logic [31:0]                           m1_rdata_o,
  output logic                                  s_req_o,
  output logic                                  s_we_o,
  output logic [31:0]                           s_addr_o,
  output logic [31:0]                           s_wdata_o,
  output logic [3:0]                            s_be_o,
  input  logic                                  s_ack_i,
  input  logic                                  s_resp_i,
  input  logic [31:0]                           s_rdata_i,
  output logic                                  err_o,
  output logic [$clog2(RESP_DEPTH):0]           outstanding_o
);

  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, HOLD_M0, HOLD_M1} state_t;

  state_t                  state;
  logic                    rr_ptr;
  logic [RESP_DEPTH-1:0]   id_fifo;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    err_q;

  logic fifo_full;
  logic win;
  logic grant;
  logic accept;
  logic push;
  logic pop;
  logic head_id;

  assign fifo_full = (count == CNT_W'(RESP_DEPTH));

  // Winner selection: a held grant owns the slave; otherwise round-robin on contention
  always_comb begin
    win   = 1'b0;
    grant = 1'b0;
    case (state)
      HOLD_M0: begin
        win   = 1'b0;
        grant = m0_req_i;
      end
      HOLD_M1: begin
        win   = 1'b1;
        grant = m1_req_i;
      end
      default: begin
        win   = (m0_req_i && m1_req_i) ? rr_ptr : m1_req_i;
        grant = m0_req_i | m1_req_i;
      end
    endcase
    grant = grant & ~fifo_full & ~rst_i;
  end

  // Slave command forwarding; fields are zero unless a command is presented
  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_be_o    = '0;
    if (grant) begin
      s_req_o   = 1'b1;
      s_we_o    = win ? m1_we_i    : m0_we_i;
      s_addr_o  = win ? m1_addr_i  : m0_addr_i;
      s_wdata_o = win ? m1_wdata_i : m0_wdata_i;
      s_be_o    = win ? m1_be_i    : m0_be_i;
    end
  end

  assign accept   = grant & s_ack_i;
  assign m0_ack_o = accept & ~win;
  assign m1_ack_o = accept & win;
  assign push     = accept & ~s_we_o;

  // Response routing to the master at the FIFO head; stray responses are dropped
  assign head_id    = id_fifo[rd_ptr];
  assign pop        = s_resp_i & (count != '0) & ~rst_i;
  assign m0_resp_o  = pop & ~head_id;
  assign m1_resp_o  = pop & head_id;
  assign m0_rdata_o = m0_resp_o ? s_rdata_i : '0;
  assign m1_rdata_o = m1_resp_o ? s_rdata_i : '0;

  assign err_o         = err_q & ~rst_i;
  assign outstanding_o = rst_i ? '0 : count;

  // Arbitration FSM and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else if (accept) begin
      state  <= IDLE;
      rr_ptr <= ~win;
    end else if (grant) begin
      state  <= win ? HOLD_M1 : HOLD_M0;
    end
  end

  // Ordering FIFO of master IDs for reads in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= win;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (s_resp_i && (count == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
